nv_ram_rwsthp_gen: RTL and testbench

Parametrised two-port (one read, one write) synchronous RAM model with a read-address register, a gated output register and an output bypass mux; the generalised successor of the fixed-size rwsthp RAM models used throughout the NVDLA core FIFOs and buffers. Adds the following on top of the fixed-size models:
- configurable depth and width;
- selectable read/write collision semantics;
- a read-valid pipeline;
- out-of-range address handling;
- optional per-word parity.

---
 rtl/nv_ram_rwsthp_gen.sv | 123 ++++++++++++
 tb/tb_nv_ram_rwsthp_gen.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nv_ram_rwsthp_gen.sv
// One-read/one-write synchronous RAM with registered read address, gated output register and bypass mux.
// Optional per-word parity storage and checking is enabled by defining NV_RAM_PARITY_EN.
module nv_ram_rwsthp_gen #(
  parameter int DEPTH    = 20,
  parameter int WIDTH    = 16,
  parameter int AW       = 5,
  parameter bit WR_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [AW-1:0]    ra,
  input  logic             re,
  input  logic             ore,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  output logic             dout_oob,
  output logic             par_err,
  input  logic [AW-1:0]    wa,
  input  logic             we,
  input  logic [WIDTH-1:0] di,
  input  logic             byp_sel,
  input  logic [WIDTH-1:0] dbyp,
  input  logic [31:0]      pwrbus_ram_pd
);

`ifdef NV_RAM_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [MW-1:0] mem [DEPTH];

  logic          ra_ok;
  logic          wa_ok;
  logic [AW-1:0] ra_p1;
  logic          rd_vld_p1;
  logic          oob_p1;
  logic          col_p1;
  logic [MW-1:0] col_data_p1;
  logic [MW-1:0] ram_word;
  logic          unused_pwr;

  // Power-down bus only matters to the physical macro.
  assign unused_pwr = ^pwrbus_ram_pd;

  function automatic logic [MW-1:0] pack_word(input logic [WIDTH-1:0] d);
`ifdef NV_RAM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  assign ra_ok = ({{(32-AW){1'b0}}, ra} < 32'(DEPTH));
  assign wa_ok = ({{(32-AW){1'b0}}, wa} < 32'(DEPTH));

  // Array write: out-of-range addresses are silently dropped
  always_ff @(posedge clk) begin
    if (we && wa_ok) begin
      mem[wa[IW-1:0]] <= pack_word(di);
    end
  end

  // Stage p1: read address capture; a read-first collision snapshots the pre-write word
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ra_p1       <= '0;
      rd_vld_p1   <= 1'b0;
      oob_p1      <= 1'b0;
      col_p1      <= 1'b0;
      col_data_p1 <= '0;
    end else if (re) begin
      ra_p1       <= ra;
      rd_vld_p1   <= 1'b1;
      oob_p1      <= !ra_ok;
      col_p1      <= we && (wa == ra) && (WR_FIRST == 1'b0);
      col_data_p1 <= ra_ok ? mem[ra[IW-1:0]] : '0;
    end else if (ore) begin
      rd_vld_p1   <= 1'b0;
    end
  end

  // Live array lookup so writes landing after the read are still seen
  always_comb begin
    ram_word = '0;
    if (oob_p1) begin
      ram_word = '0;
    end else if (col_p1) begin
      ram_word = col_data_p1;
    end else begin
      ram_word = mem[ra_p1[IW-1:0]];
    end
  end

  // Stage p2: gated output register with bypass mux
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout     <= '0;
      dout_vld <= 1'b0;
      dout_oob <= 1'b0;
    end else if (ore) begin
      dout     <= byp_sel ? dbyp : ram_word[WIDTH-1:0];
      dout_vld <= byp_sel | rd_vld_p1;
      dout_oob <= !byp_sel & rd_vld_p1 & oob_p1;
    end
  end

`ifdef NV_RAM_PARITY_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      par_err <= 1'b0;
    end else if (ore) begin
      par_err <= !byp_sel & rd_vld_p1 & !oob_p1 &
                 ((^ram_word[WIDTH-1:0]) != ram_word[WIDTH]);
    end
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_nv_ram_rwsthp_gen.sv
// Randomised self-checking bench for nv_ram_rwsthp_gen; runs write-first and read-first instances side by side.
// Parity checks are compiled in when NV_RAM_PARITY_EN is defined.
module tb_nv_ram_rwsthp_gen;
  localparam int DEPTH = 20;
  localparam int WIDTH = 16;
  localparam int AW    = 5;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [AW-1:0]    ra = '0;
  logic             re = 1'b0;
  logic             ore = 1'b0;
  logic [AW-1:0]    wa = '0;
  logic             we = 1'b0;
  logic [WIDTH-1:0] di = '0;
  logic             byp_sel = 1'b0;
  logic [WIDTH-1:0] dbyp = '0;
  logic [31:0]      pwrbus_ram_pd = '0;

  // index 0: read-first instance, index 1: write-first instance
  logic [WIDTH-1:0] dout_a [2];
  logic             vld_a  [2];
  logic             oob_a  [2];
  logic             par_a  [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nv_ram_rwsthp_gen #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW), .WR_FIRST(1'b0)) u_dut_rf (
    .clk(clk), .rstn(rstn), .ra(ra), .re(re), .ore(ore),
    .dout(dout_a[0]), .dout_vld(vld_a[0]), .dout_oob(oob_a[0]), .par_err(par_a[0]),
    .wa(wa), .we(we), .di(di), .byp_sel(byp_sel), .dbyp(dbyp), .pwrbus_ram_pd(pwrbus_ram_pd)
  );

  nv_ram_rwsthp_gen #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW), .WR_FIRST(1'b1)) u_dut_wf (
    .clk(clk), .rstn(rstn), .ra(ra), .re(re), .ore(ore),
    .dout(dout_a[1]), .dout_vld(vld_a[1]), .dout_oob(oob_a[1]), .par_err(par_a[1]),
    .wa(wa), .we(we), .di(di), .byp_sel(byp_sel), .dbyp(dbyp), .pwrbus_ram_pd(pwrbus_ram_pd)
  );

  // Reference model: word contents, corrupted-word flags and the last issued read per instance
  logic [WIDTH-1:0] mem_m   [DEPTH];
  bit               bad_m   [DEPTH];
  bit               pend    [2];
  int               la      [2];
  bit               loob    [2];
  bit               snap_v  [2];
  logic [WIDTH-1:0] snap    [2];
  bit               snap_bad[2];
  logic [WIDTH-1:0] e_dout  [2];
  bit               e_vld   [2];
  bit               e_oob   [2];
  bit               e_par   [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      pend[k] = 0; la[k] = 0; loob[k] = 0; snap_v[k] = 0; snap[k] = '0; snap_bad[k] = 0;
      e_dout[k] = '0; e_vld[k] = 0; e_oob[k] = 0; e_par[k] = 0;
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("dout[%0d]", k), 32'(dout_a[k]), 32'(e_dout[k]));
      check_eq($sformatf("vld[%0d]", k), 32'(vld_a[k]), 32'(e_vld[k]));
      check_eq($sformatf("oob[%0d]", k), 32'(oob_a[k]), 32'(e_oob[k]));
      check_eq($sformatf("par[%0d]", k), 32'(par_a[k]), 32'(e_par[k]));
    end
  endtask

  // Apply one cycle of inputs (called at a falling edge), advance model, check after the rising edge
  task automatic drive(input bit i_re, input int i_ra, input bit i_ore, input bit i_we,
                       input int i_wa, input logic [WIDTH-1:0] i_di,
                       input bit i_byp, input logic [WIDTH-1:0] i_dbyp);
    logic [WIDTH-1:0] word;
    bit               wbad;
    re = i_re; ra = i_ra[AW-1:0]; ore = i_ore; we = i_we; wa = i_wa[AW-1:0];
    di = i_di; byp_sel = i_byp; dbyp = i_dbyp;
    for (int k = 0; k < 2; k++) begin
      word = '0; wbad = 0;
      if (loob[k]) begin
        word = '0;
      end else if (snap_v[k]) begin
        word = snap[k]; wbad = snap_bad[k];
      end else begin
        word = mem_m[la[k]]; wbad = bad_m[la[k]];
      end
      if (i_ore) begin
        e_dout[k] = i_byp ? i_dbyp : word;
        e_vld[k]  = i_byp || pend[k];
        e_oob[k]  = !i_byp && pend[k] && loob[k];
`ifdef NV_RAM_PARITY_EN
        e_par[k]  = !i_byp && pend[k] && !loob[k] && wbad;
`else
        e_par[k]  = 0;
`endif
      end
      if (i_re) begin
        pend[k]   = 1;
        la[k]     = i_ra;
        loob[k]   = (i_ra >= DEPTH);
        snap_v[k] = (k == 0) && i_we && (i_wa == i_ra);
        snap[k]   = (i_ra < DEPTH) ? mem_m[i_ra] : '0;
        snap_bad[k] = (i_ra < DEPTH) ? bad_m[i_ra] : 0;
      end else if (i_ore) begin
        pend[k] = 0;
      end
    end
    if (i_we && i_wa < DEPTH) begin
      mem_m[i_wa] = i_di;
      bad_m[i_wa] = 0;
    end
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, '0, 0, '0);
  endtask

  task automatic write(input int a, input logic [WIDTH-1:0] d);
    drive(0, 0, 0, 1, a, d, 0, '0);
  endtask

  task automatic read2(input int a);
    drive(1, a, 0, 0, 0, '0, 0, '0);
    drive(0, 0, 1, 0, 0, '0, 0, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int a = 0; a < DEPTH; a++) begin
      mem_m[a] = '0; bad_m[a] = 0;
    end
    model_reset();

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs();
    rstn = 1'b1;
    @(negedge clk);

    // fill M[i] = i
    for (int a = 0; a < DEPTH; a++) write(a, WIDTH'(a));

    // streaming: one read per cycle, dout lags ra by one ore edge
    for (int i = 0; i <= 20; i++) begin
      drive(i < 20, i, 1, 0, 0, '0, 0, '0);
      if (i >= 1) begin
        check_eq("stream_dout", 32'(dout_a[1]), 32'(i - 1));
        check_eq("stream_vld", 32'(vld_a[0]), 32'd1);
      end
    end

    // basic write then read
    write(3, 16'hA5A5);
    read2(3);
    check_eq("basic_dout", 32'(dout_a[1]), 32'hA5A5);
    check_eq("basic_vld", 32'(vld_a[1]), 32'd1);

    // same-cycle collision
    write(7, 16'h1111);
    drive(1, 7, 0, 1, 7, 16'h2222, 0, '0);
    drive(0, 0, 1, 0, 0, '0, 0, '0);
    check_eq("col_wf", 32'(dout_a[1]), 32'h2222);
    check_eq("col_rf", 32'(dout_a[0]), 32'h1111);
    read2(7);
    check_eq("col_rf_after", 32'(dout_a[0]), 32'h2222);

    // write to ra_d in the ore cycle: old word is captured
    drive(1, 9, 0, 0, 0, '0, 0, '0);
    drive(0, 0, 1, 1, 9, 16'h9999, 0, '0);
    check_eq("late_write", 32'(dout_a[1]), 32'd9);

    // bypass with no pending read, then idle ore
    drive(0, 0, 1, 0, 0, '0, 1, 16'hBEEF);
    check_eq("byp_dout", 32'(dout_a[0]), 32'hBEEF);
    check_eq("byp_vld", 32'(vld_a[0]), 32'd1);
    drive(0, 0, 1, 0, 0, '0, 0, '0);
    check_eq("idle_vld", 32'(vld_a[1]), 32'd0);

    // out-of-range write and read
    write(25, 16'h7777);
    read2(25);
    check_eq("oob_dout", 32'(dout_a[1]), 32'd0);
    check_eq("oob_flag", 32'(oob_a[1]), 32'd1);
    check_eq("oob_vld", 32'(vld_a[1]), 32'd1);

    // asynchronous reset mid-read keeps the array
    drive(1, 4, 0, 0, 0, '0, 0, '0);
    #2 rstn = 1'b0;
    model_reset();
    #1 check_outputs();
    re = 1'b0; ore = 1'b0; we = 1'b0; byp_sel = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    read2(4);
    check_eq("after_rst", 32'(dout_a[0]), 32'd4);

`ifdef NV_RAM_PARITY_EN
    write(5, 16'h00FF);
    u_dut_rf.mem[5][0] = ~u_dut_rf.mem[5][0];
    u_dut_wf.mem[5][0] = ~u_dut_wf.mem[5][0];
    mem_m[5] = mem_m[5] ^ 16'h0001;
    bad_m[5] = 1;
    read2(5);
    check_eq("par_bad", 32'(par_a[1]), 32'd1);
    read2(6);
    check_eq("par_clean", 32'(par_a[1]), 32'd0);
`endif

    // randomised traffic including out-of-range addresses and forced collisions
    for (int n = 0; n < 600; n++) begin
      int r_ra, r_wa;
      r_ra = $urandom_range(0, 23);
      r_wa = ($urandom_range(0, 3) == 0) ? r_ra : $urandom_range(0, 23);
      drive($urandom_range(0, 1), r_ra, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
            r_wa, WIDTH'($urandom), $urandom_range(0, 7) == 0, WIDTH'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
